// File: rtl/if_stage_skid_reg.sv
// IF/ID pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The main register drives decode. The skid register catches the beat that was
// accepted while decode stalled, so in_ready can be a plain flop.
// Optional build macro IF_STAGE_PERF_CNT_EN adds saturating stall and flush counters.
module if_stage_skid_reg #(
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic                 in_ready_q, in_ready_d;
    logic                 accept, consume;

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;

    assign accept  = in_valid & in_ready_q;
    assign consume = out_valid & out_ready;

    // Next-state and payload steering; flush overrides every handshake.
    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            // out_pc deliberately keeps its last value; only the instruction is squashed.
            state_d      = StEmpty;
            main_instr_d = NOP_INSTR;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d      = StOne;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                StOne: begin
                    if (accept && consume) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (accept) begin
                        state_d      = StFull;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end else if (consume) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (consume) begin
                        state_d      = StOne;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d = (state_d != StFull);
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StEmpty;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            in_ready_q   <= in_ready_d;
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]  held;
    logic [1:0]  discarded;
    logic [16:0] flush_sum;

    // Entries lost to a flush: those held, minus the head if decode takes it that cycle.
    always_comb begin
        held = 2'd0;
        unique case (state_q)
            StOne:   held = 2'd1;
            StFull:  held = 2'd2;
            default: held = 2'd0;
        endcase
        discarded = held - {1'b0, consume};
        flush_sum = {1'b0, flush_cnt_q} + {15'd0, discarded};

        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        flush_cnt_d = flush_cnt_q;
        if (flush) begin
            flush_cnt_d = flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_skid_reg.sv
// Self-checking bench for if_stage_skid_reg: queue-based reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_if_stage_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h2008_0005;
    localparam logic [31:0] I1  = 32'h2009_0003;
    localparam logic [31:0] I2  = 32'h0109_5020;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
`ifdef IF_STAGE_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: FIFO of at most two entries plus the last shown payload.
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic        m_in_ready;
    logic [31:0] m_pc, m_instr;
    int          m_stall, m_flush;

    if_stage_skid_reg #(
        .PC_W     (32),
        .INSTR_W  (32),
        .NOP_INSTR(NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_in.delete();
        m_in_ready = 1'b1;
        m_pc       = '0;
        m_instr    = NOP;
        m_stall    = 0;
        m_flush    = 0;
    endtask

    // One clock edge of the reference model, using the inputs held across that edge.
    task automatic model_edge();
        bit acc, con;
        acc = in_valid && m_in_ready;
        con = (q_pc.size() > 0) && out_ready;
        if ((q_pc.size() > 0) && !out_ready && m_stall < 65535) m_stall++;
        if (flush) begin
            m_flush = m_flush + q_pc.size() - int'(con);
            if (m_flush > 65535) m_flush = 65535;
            q_pc.delete();
            q_in.delete();
            m_instr    = NOP;
            m_in_ready = 1'b1;
        end else begin
            if (con) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (acc) begin
                q_pc.push_back(in_pc);
                q_in.push_back(in_instr);
            end
            if (q_pc.size() > 0) begin
                m_pc    = q_pc[0];
                m_instr = q_in[0];
            end
            m_in_ready = (q_pc.size() < 2);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, return at the following falling edge.
    task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                        input bit ordy, input bit fl);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc out_valid", {31'd0, out_valid}, {31'd0, q_pc.size() > 0});
            chk("cyc in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
            chk("cyc out_pc", out_pc, m_pc);
            chk("cyc out_instr", out_instr, m_instr);
`ifdef IF_STAGE_PERF_CNT_EN
            chk("cyc stall_cnt", {16'd0, stall_cnt}, m_stall);
            chk("cyc flush_cnt", {16'd0, flush_cnt}, m_flush);
`endif
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        chk_en = 1'b1;

        // Reset values
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_instr", out_instr, NOP);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming at one beat per clock
        step(1'b1, 32'd4, I0, 1'b1, 1'b0);
        chk("stream v0", {31'd0, out_valid}, 32'd1);
        chk("stream pc0", out_pc, 32'd4);
        chk("stream in0", out_instr, I0);
        step(1'b1, 32'd8, I1, 1'b1, 1'b0);
        chk("stream pc1", out_pc, 32'd8);
        chk("stream in1", out_instr, I1);
        step(1'b1, 32'd12, I2, 1'b1, 1'b0);
        chk("stream v2", {31'd0, out_valid}, 32'd1);
        chk("stream pc2", out_pc, 32'd12);
        chk("stream in2", out_instr, I2);
        idle();
        chk("stream drained", {31'd0, out_valid}, 32'd0);
        chk("stream pc hold", out_pc, 32'd12);

        // Backpressure: two accepted, third held by fetch until space frees up
        step(1'b1, 32'd4, I0, 1'b0, 1'b0);
        chk("bp pc a", out_pc, 32'd4);
        step(1'b1, 32'd8, I1, 1'b0, 1'b0);
        chk("bp full ready", {31'd0, in_ready}, 32'd0);
        chk("bp pc b", out_pc, 32'd4);
        step(1'b1, 32'd12, I2, 1'b0, 1'b0);
        chk("bp still full", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'd12, I2, 1'b1, 1'b0);
        chk("bp pc skid", out_pc, 32'd8);
        chk("bp ready back", {31'd0, in_ready}, 32'd1);
        step(1'b1, 32'd12, I2, 1'b1, 1'b0);
        chk("bp pc third", out_pc, 32'd12);
        chk("bp in third", out_instr, I2);
        idle();
        chk("bp drained", {31'd0, out_valid}, 32'd0);

        // Flush while full, with a beat offered in the flush cycle
        step(1'b1, 32'd100, I0, 1'b0, 1'b0);
        step(1'b1, 32'd104, I1, 1'b0, 1'b0);
        step(1'b1, 32'd108, I2, 1'b0, 1'b1);
        chk("flush valid", {31'd0, out_valid}, 32'd0);
        chk("flush nop", out_instr, NOP);
        chk("flush pc hold", out_pc, 32'd100);
        chk("flush ready", {31'd0, in_ready}, 32'd1);
        idle();
        chk("flush no ghost", {31'd0, out_valid}, 32'd0);

        // Flush and accept in the same cycle
        step(1'b1, 32'd16, I0, 1'b1, 1'b1);
        chk("fa dropped", {31'd0, out_valid}, 32'd0);
        step(1'b1, 32'd20, I1, 1'b1, 1'b0);
        chk("fa next valid", {31'd0, out_valid}, 32'd1);
        chk("fa next pc", out_pc, 32'd20);
        idle();

        // Asynchronous reset mid-operation, observed before any clock edge
        step(1'b1, 32'd40, I2, 1'b0, 1'b0);
        step(1'b1, 32'd44, I1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("arst valid", {31'd0, out_valid}, 32'd0);
        chk("arst pc", out_pc, 32'd0);
        chk("arst instr", out_instr, NOP);
        chk("arst ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

`ifdef IF_STAGE_PERF_CNT_EN
        // Five stall edges, the last one being a flush with two held entries
        step(1'b1, 32'd4, I0, 1'b0, 1'b0);
        step(1'b1, 32'd8, I1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("perf stall5", {16'd0, stall_cnt}, 32'd5);
        chk("perf flush2", {16'd0, flush_cnt}, 32'd2);
        for (int i = 0; i < 70000; i++) step(1'b1, 32'd64, I0, 1'b0, 1'b0);
        chk("perf stall sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage_skid_reg.md
Name: if_stage_skid_reg

Overview:
- Parametrised successor to the IF/ID pipeline register: carries PC and instruction from the fetch stage to decode.
- Adds a valid/ready handshake and a 2-entry skid buffer, so a decode stall never drops a fetched word and throughput stays at one instruction per clock.
- Flush invalidates all held entries and presents a configurable NOP.
- Sits between the fetch stage and the ID stage.

Parameters:
- PC_W, 32, width of PC payload.
- INSTR_W, 32, width of instruction payload.
- NOP_INSTR, {INSTR_W{1'b0}}, instruction value driven after reset/flush.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous flush; highest priority after reset.
- in_valid  input  1  fetch presents a valid PC/instruction.
- in_ready  output  1  stage can accept; transfer when in_valid & in_ready.
- in_pc  input  PC_W  fetched PC (PC+4 value from fetch).
- in_instr  input  INSTR_W  fetched instruction.
- out_valid  output  1  out_pc/out_instr hold a valid entry.
- out_ready  input  1  decode consumes; transfer when out_valid & out_ready.
- out_pc  output  PC_W  PC to decode.
- out_instr  output  INSTR_W  instruction to decode.

Behaviour:
- Reset (rst=0, asynchronous): out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, skid entry invalid, state=EMPTY.
- Storage: main register (drives outputs) plus one skid register.
- in_ready is registered and equals !skid_valid; it has no combinational path from out_ready.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- States and transitions:
  - EMPTY (out_valid=0):
    - accept -> ONE; main <= in.
    - Otherwise stay.
  - ONE (out_valid=1, skid empty):
    - accept & consume -> ONE; main <= in.
    - accept & !consume -> FULL; skid <= in; main holds; in_ready falls next cycle.
    - !accept & consume -> EMPTY.
    - Neither -> hold.
  - FULL (out_valid=1, skid valid, in_ready=0):
    - consume -> ONE; main <= skid; in_ready=1 next cycle.
    - Otherwise hold. in_valid is ignored.
- Latency: accept in cycle N -> out_valid=1 with that data in cycle N+1 (from EMPTY, or ONE with consume).
- Throughput: 1 transfer/clock when out_ready is held high.
- Ordering is strictly FIFO. No entry is ever duplicated or dropped except by flush.
- Flush (flush=1 at an edge, regardless of state or handshakes):
  - Next state EMPTY; out_valid=0; skid invalid; in_ready=1; out_instr=NOP_INSTR.
  - out_pc holds its previous value.
  - An in_valid beat presented in the flush cycle is discarded, even though in_ready=1; fetch must treat it as not taken.
  - A consume in the flush cycle is still a completed transfer for decode.
- When out_valid=0 (not via flush), out_pc/out_instr keep their last values; decode must qualify them with out_valid.
- Reset asserted mid-operation: immediate return to reset values; in-flight entries are lost.
- Payload widths are independent; no arithmetic on the payload.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[15:0] and flush_cnt[15:0].
  - Both reset to 0 on rst and saturate at 16'hFFFF (no wrap).
  - stall_cnt increments each cycle with out_valid & !out_ready.
  - flush_cnt increments by the number of valid entries (0, 1 or 2) discarded per flush, using a saturating add.
- When undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: drive rst=0 asynchronously mid-cycle -> out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1 without waiting for a clock edge.
- Streaming: out_ready=1; push PC 4,8,12 with instrs 0x20080005, 0x20090003, 0x01095020 on consecutive cycles -> each appears one cycle later; out_valid is high for 3 consecutive cycles.
- Backpressure: out_ready=0 after first beat, push 3 beats -> in_ready=0 after 2 accepted; third beat is held by fetch. Raise out_ready -> PC 4,8,12 delivered in order, none lost.
- Flush in FULL: hold two entries, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc unchanged, in_ready=1; the flush-cycle beat never appears.
- Flush vs. accept: flush and accept of PC 16 in the same cycle -> PC 16 is not delivered; a beat on the next cycle (PC 20) appears one cycle later.
- Counters (IF_STAGE_PERF_CNT_EN): 5 stall cycles, then flush with 2 entries -> stall_cnt=5, flush_cnt=2; forcing 70000 stall cycles -> stall_cnt=16'hFFFF.
